dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port byte-addressed data memory (32-bit little-endian word access, combinational read, posedge write). It grants the memory to one of two requesters: m0 is the CPU MEM stage and m1 is the DMA/debug loader. The grant is round-robin. The block sequences a fixed multi-cycle access to model slow memory and returns a one-cycle ack with read data. Misaligned and out-of-range accesses are rejected without touching memory.

Parameters:
LATENCY, 2, number of ACCESS cycles per transaction (legal range 1..15).
MEM_BYTES, 32, size of the downstream memory in bytes; legal word addresses are 0..MEM_BYTES-4.

Ports:
clk_i  in  1  clock; all state changes on the posedge.
rst_i  in  1  reset; asynchronous, active-high.
m0_req_i  in  1  m0 request; held high until m0_ack_o.
m0_we_i  in  1  m0 operation: 1 = write, 0 = read.
m0_addr_i  in  32  m0 byte address.
m0_data_i  in  32  m0 write data.
m0_ack_o  out  1  one-cycle completion pulse to m0.
m0_err_o  out  1  valid with m0_ack_o; 1 = access rejected.
m0_data_o  out  32  m0 read data; valid with m0_ack_o.
m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_ack_o, m1_err_o, m1_data_o: same widths and meanings as the m0 ports, for m1.
mem_addr_o  out  32  address to the data memory.
mem_data_o  out  32  write data to the data memory.
mem_read_o  out  1  MemRead strobe to the data memory.
mem_write_o  out  1  MemWrite strobe to the data memory.
mem_data_i  in  32  read data from the data memory (combinational).
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state IDLE; all ack/err outputs 0; m0_data_o and m1_data_o 0; all mem_* outputs 0; busy_o 0; cycle counter 0; last_grant = 1, so m0 wins the first tie.
- IDLE: sample the requests.
  - If only one master requests, grant it.
  - If both request, grant the master that is not last_grant.
  - On grant, latch that master's we, addr and wdata, and update last_grant.
  - Legal access: addr[1:0] == 0 and addr <= MEM_BYTES-4. Go to ACCESS with counter = LATENCY-1.
  - Illegal access: go directly to RESP with err = 1.
- ACCESS: mem_addr_o and mem_data_o are driven from the latched registers.
  - Read: mem_read_o is high for every ACCESS cycle. On the cycle where the counter reaches 0, mem_data_i is captured into the granted master's data register.
  - Write: mem_write_o is high only on the counter == 0 cycle. This gives exactly one write posedge.
  - The counter decrements each cycle; at 0, go to RESP.
- RESP: the granted master's ack_o is high for exactly one cycle, with err_o and data_o valid. The other master's outputs stay 0. Next state is IDLE.
- Latency: a request seen in IDLE at cycle 0 is acked in cycle LATENCY+1. An error request is acked in cycle 1.
- Requests are ignored in ACCESS and RESP. A master that holds req high through its ack cycle starts a new transaction on the next IDLE sample.
- Fairness: under continuous requests from both masters, grants alternate m0, m1, m0, and so on.
- Error responses: data_o = 0. mem_read_o and mem_write_o stay low for the whole transaction.
- Write transactions return data_o = 0.
- data_o holds its last value between acks; requesters qualify it with ack.
- mem_addr_o and mem_data_o are 0 in IDLE and in RESP.
- Reset mid-operation: all state and outputs return to their reset values immediately. A pending write is dropped, because mem_write_o is decoded from state and falls asynchronously. No ack is issued.
- Address arithmetic uses the full 32 bits. An address near 0xFFFFFFFF is out of range; it is never wrapped.

Decomposition:
- Package dmem_pkg holds:
  - state encoding for IDLE, ACCESS and RESP;
  - default MEM_BYTES;
  - the alignment mask constant 2'b00;
  - the counter width (4 bits).
- Sub-module rr_arb2 is the 2-way round-robin grant logic.
  - Inputs: req[1:0], last_grant.
  - Output: grant[1:0].
  - It is combinational, with the last_grant register kept in the parent.

Test Plan:
- LATENCY=2, m0 reads addr 0x4 while memory bytes 4..7 = 11 22 33 44 -> m0_ack_o in cycle 3, m0_data_o = 0x44332211, mem_read_o high in cycles 1-2, err 0.
- m1 writes 0xDEADBEEF to addr 0x8, then m0 reads 0x8 -> exactly one mem_write_o cycle; m0_data_o = 0xDEADBEEF.
- m0 and m1 both hold req continuously for 4 transactions -> grant order m0, m1, m0, m1; no cycle has both acks high.
- m0 reads addr 0x6 (misaligned), then m1 reads addr 0x1C then 0x20 (MEM_BYTES=32) -> 0x6: ack in cycle 1, err 1, data 0, no mem strobes; 0x1C: legal; 0x20: err 1.
- rst_i pulsed in the ACCESS cycle of a write to 0x0 holding 0 -> state IDLE immediately, mem_write_o low, byte 0 unchanged, no ack; the next request is served with m0 priority.
- LATENCY=1, back-to-back m0 reads -> ack every 3rd cycle (IDLE, ACCESS, RESP); busy_o low only in the IDLE cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int DEF_MEM_BYTES = 32;

    // Word accesses must have these two low address bits
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    // Access-cycle counter width; bounds LATENCY to 1..15
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    // Word-aligned and within the last full word of memory (no wrap)
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] max_addr);
        return (addr[1:0] == ALIGN_MASK) && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester wins; on a tie the master not granted last time wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter and slow-access sequencer for the data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_data_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_data_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_i,

    output logic        busy_o
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);
    localparam cnt_t        CNT_INIT = cnt_t'(LATENCY - 1);

    state_t      state_q;
    state_t      state_d;
    cnt_t        cnt_q;
    logic        last_grant_q;
    logic        sel_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] m0_data_q;
    logic [31:0] m1_data_q;

    logic [1:0]  grant;
    logic        grant_any;
    logic        grant_sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign grant_any = |grant;
    assign grant_sel = grant[1];
    assign sel_we    = grant_sel ? m1_we_i   : m0_we_i;
    assign sel_addr  = grant_sel ? m1_addr_i : m0_addr_i;
    assign sel_wdata = grant_sel ? m1_data_i : m0_data_i;
    assign sel_legal = addr_legal(sel_addr, MAX_ADDR);

    assign m0_data_o = m0_data_q;
    assign m1_data_o = m1_data_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: rejected requests skip straight to the response
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = sel_legal ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transaction latch, access counter and per-master read-data registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m0_data_q    <= '0;
            m1_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        sel_q        <= grant_sel;
                        last_grant_q <= grant_sel;
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        err_q        <= ~sel_legal;
                        cnt_q        <= CNT_INIT;
                        // Writes and rejects answer with zero data
                        if (!sel_legal || sel_we) begin
                            if (grant_sel) begin
                                m1_data_q <= '0;
                            end else begin
                                m0_data_q <= '0;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            if (sel_q) begin
                                m1_data_q <= mem_data_i;
                            end else begin
                                m0_data_q <= mem_data_i;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so a reset drops strobes and acks at once
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                mem_addr_o  = addr_q;
                mem_data_o  = wdata_q;
                mem_read_o  = ~we_q;
                mem_write_o = we_q && (cnt_q == '0);
            end
            ST_RESP: begin
                m0_ack_o = ~sel_q;
                m0_err_o = ~sel_q & err_q;
                m1_ack_o = sel_q;
                m1_err_o = sel_q & err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    logic        r2_req, r2_ack, r2_err, r2_m1_ack, r2_m1_err;
    logic [31:0] r2_addr, r2_rdata, r2_m1_rdata;
    logic [31:0] r2_mem_addr, r2_mem_wdata, r2_mem_rdata;
    logic        r2_mem_read, r2_mem_write, r2_busy;

    dmem_arbiter #(.LATENCY(LAT), .MEM_BYTES(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_data_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_data_o(m1_rdata),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .mem_data_i(mem_rdata), .busy_o(busy)
    );

    dmem_arbiter #(.LATENCY(1), .MEM_BYTES(32)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(r2_req), .m0_we_i(1'b0), .m0_addr_i(r2_addr), .m0_data_i(32'h0),
        .m0_ack_o(r2_ack), .m0_err_o(r2_err), .m0_data_o(r2_rdata),
        .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'h0), .m1_data_i(32'h0),
        .m1_ack_o(r2_m1_ack), .m1_err_o(r2_m1_err), .m1_data_o(r2_m1_rdata),
        .mem_addr_o(r2_mem_addr), .mem_data_o(r2_mem_wdata), .mem_read_o(r2_mem_read),
        .mem_write_o(r2_mem_write), .mem_data_i(r2_mem_rdata), .busy_o(r2_busy)
    );

    assign r2_mem_rdata = r2_mem_addr ^ 32'h5A5A_0000;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Memory model and an independent reference image
    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];

    assign mem_rdata = {mem[{mem_addr[4:2], 2'd3}], mem[{mem_addr[4:2], 2'd2}],
                        mem[{mem_addr[4:2], 2'd1}], mem[{mem_addr[4:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_write) begin
            mem[{mem_addr[4:2], 2'd0}] = mem_wdata[7:0];
            mem[{mem_addr[4:2], 2'd1}] = mem_wdata[15:8];
            mem[{mem_addr[4:2], 2'd2}] = mem_wdata[23:16];
            mem[{mem_addr[4:2], 2'd3}] = mem_wdata[31:24];
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [4:0] b;
        b = {a[4:2], 2'b00};
        return {ref_mem[b + 5'd3], ref_mem[b + 5'd2], ref_mem[b + 5'd1], ref_mem[b]};
    endfunction

    typedef struct packed { logic err; logic [31:0] data; } resp_t;
    resp_t q0[$];
    resp_t q1[$];
    resp_t e0, e1;

    // Scoreboard: every ack must match the oldest expectation of that master
    always @(negedge clk) begin
        if (m0_ack || m1_ack) check("ack_excl", 32'(m0_ack & m1_ack), 32'd0);
        if (m0_ack) begin
            if (q0.size() == 0) check("m0_unexpected_ack", 32'd1, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("m0_err", 32'(m0_err), 32'(e0.err));
                check("m0_data", m0_rdata, e0.data);
            end
        end
        if (m1_ack) begin
            if (q1.size() == 0) check("m1_unexpected_ack", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("m1_err", 32'(m1_err), 32'(e1.err));
                check("m1_data", m1_rdata, e1.data);
            end
        end
    end

    task automatic run_single(input logic m, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic exp_err,
                              input logic [31:0] exp_data, input string tag);
        int rd, wr, lat;
        resp_t e;
        e.err = exp_err;
        e.data = exp_data;
        if (m) q1.push_back(e); else q0.push_back(e);
        @(posedge clk); #1;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        rd = 0; wr = 0; lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            rd += int'(mem_read);
            wr += int'(mem_write);
            if ((m && m1_ack) || (!m && m0_ack)) begin
                lat = k;
                check({tag, "_resp_addr"}, mem_addr, 32'd0);
                break;
            end
        end
        if (lat < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'(LAT + 1));
        check({tag, "_rd_cycles"}, 32'(rd), (!exp_err && !we) ? 32'(LAT) : 32'd0);
        check({tag, "_wr_cycles"}, 32'(wr), (!exp_err && we) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        if (m) m1_req = 0; else m0_req = 0;
    endtask

    int order[4];
    int n_ack;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'((i * 37) + 3);
        end
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

        rst = 1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        r2_req = 0; r2_addr = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_wdata, 32'd0);
        check("rst_m0_data", m0_rdata, 32'd0);
        check("rst_m1_data", m1_rdata, 32'd0);
        @(posedge clk); #1 rst = 0;

        // Basic read, then rejects and range edges
        run_single(1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4433_2211, "rd4");
        run_single(1'b0, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, "rd_mis");
        run_single(1'b1, 1'b0, 32'h1C, 32'h0, 1'b0, ref_word(32'h1C), "rd_1c");
        run_single(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, "rd_20");
        run_single(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, "rd_wrap");
        run_single(1'b0, 1'b1, 32'h2, 32'h1234_5678, 1'b1, 32'h0, "wr_mis");
        check("wr_mis_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);

        // Write by m1 then read back by m0
        run_single(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0, "wr8");
        run_single(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEAD_BEEF, "rd8");

        // Reset during the write-strobe ACCESS cycle
        @(posedge clk); #1;
        m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        check("rst_mid_pre_wr", 32'(mem_write), 32'd1);
        #1 rst = 1;
        #1;
        check("rst_mid_wr", 32'(mem_write), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ack", 32'(m0_ack), 32'd0);
        m0_req = 0;
        @(posedge clk); #1 rst = 0;
        repeat (3) @(negedge clk);
        check("rst_mid_mem0", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);

        // Both masters request continuously: alternation starting with m0
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{err: 1'b0, data: ref_word(32'h10)});
            q1.push_back('{err: 1'b0, data: ref_word(32'h14)});
        end
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h14;
        n_ack = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m0_ack && n_ack < 4) begin order[n_ack] = 0; n_ack++; end
            if (m1_ack && n_ack < 4) begin order[n_ack] = 1; n_ack++; end
            if (n_ack >= 4) break;
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        check("rr_count", 32'(n_ack), 32'd4);
        check("rr_order0", 32'(order[0]), 32'd0);
        check("rr_order1", 32'(order[1]), 32'd1);
        check("rr_order2", 32'(order[2]), 32'd0);
        check("rr_order3", 32'(order[3]), 32'd1);

        // LATENCY=1 instance: held request acks every third cycle
        @(posedge clk); #1;
        r2_req = 1; r2_addr = 32'h8;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("l1_ack", 32'(r2_ack), (k % 3 == 2) ? 32'd1 : 32'd0);
            check("l1_busy", 32'(r2_busy), (k % 3 == 0) ? 32'd0 : 32'd1);
            if (r2_ack) check("l1_data", r2_rdata, 32'h5A5A_0008);
        end
        @(posedge clk); #1;
        r2_req = 0;

        repeat (5) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
